grey_pointer: RTL and testbench

- Parametrised Gray-code pointer for clock-domain crossing, e.g. one side of an asynchronous FIFO.
- Holds a local binary counter and a glitch-free registered Gray copy of it for export to the other domain.
- Synchronises the other domain's Gray pointer, decodes it to binary and reports the modular distance between the local and remote pointers.
- Generalises fixed-width combinational binary-to-Gray encoding to any width, with count direction, clear and a lookahead output.

---
 rtl/grey_pkg.sv | 23 ++
 rtl/grey_sync.sv | 32 +++
 rtl/panic.sv | 9 +
 rtl/grey_pointer.sv | 82 ++++++++
 tb/tb_grey_pointer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/grey_pkg.sv
// Shared types and Gray-code conversion helpers for pointer-style CDC blocks.
// Callers zero-extend narrower values into grey_ptr_t and truncate results.
package grey_pkg;

    localparam int GREY_MAX_WIDTH = 32;

    typedef logic [GREY_MAX_WIDTH-1:0] grey_ptr_t;

    function automatic grey_ptr_t bin2grey(input grey_ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero-extended upper bits leave the result intact.
    function automatic grey_ptr_t grey2bin(input grey_ptr_t g);
        grey_ptr_t b;
        b[GREY_MAX_WIDTH-1] = g[GREY_MAX_WIDTH-1];
        for (int i = GREY_MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/grey_sync.sv
// Reset-clearable multi-flop synchroniser for a Gray-coded bus arriving from
// another clock domain; the first stage samples the raw input with no logic in front.
module grey_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_stage [STAGES];

    // NOTE: every stage is a plain flop (not RAM), so it is cleared on reset;
    // otherwise a stale remote pointer could surface after reset is released.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q_o = r_stage[STAGES-1];

endmodule

// File: rtl/panic.sv
// Elaboration-time trap for illegal parameter combinations; instantiated only
// from a generate branch that should never be taken in a legal configuration.
module panic #(
    parameter string MSG = "illegal parameterisation"
) ();

    $error("panic: %s", MSG);

endmodule

// File: rtl/grey_pointer.sv
// Gray-code pointer for one side of a clock-domain crossing: local binary/Gray
// counter, synchronised remote pointer and the modular distance between them.
module grey_pointer
    import grey_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_DOWN  = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] grey_o,
    output logic [WIDTH-1:0] grey_next_o,
    input  logic [WIDTH-1:0] remote_grey_i,
    output logic [WIDTH-1:0] remote_bin_o,
    output logic [WIDTH-1:0] diff_o
);

    if (WIDTH < 2 || WIDTH > GREY_MAX_WIDTH || SYNC_STAGES < 2) begin : g_param_check
        panic #(.MSG("grey_pointer: WIDTH must be 2..32 and SYNC_STAGES >= 2")) u_panic ();
    end

    // Adding all-ones is a decrement modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] STEP = (COUNT_DOWN != 0) ? {WIDTH{1'b1}} : WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_grey;
    logic [WIDTH-1:0] r_remote_bin;
    logic [WIDTH-1:0] w_bin_step;
    logic [WIDTH-1:0] w_grey_step;
    logic [WIDTH-1:0] w_remote_grey_sync;
    logic [WIDTH-1:0] w_remote_bin;

    assign w_bin_step  = r_bin + STEP;
    assign w_grey_step = WIDTH'(bin2grey(grey_ptr_t'(w_bin_step)));

    // Gray copy is loaded from the same next-binary value so grey_o never lags bin_o.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // from pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bin  <= '0;
            r_grey <= '0;
        end else if (clr_i) begin
            r_bin  <= '0;
            r_grey <= '0;
        end else if (inc_i) begin
            r_bin  <= w_bin_step;
            r_grey <= w_grey_step;
        end
    end

    grey_sync #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (remote_grey_i),
        .q_o   (w_remote_grey_sync)
    );

    assign w_remote_bin = WIDTH'(grey2bin(grey_ptr_t'(w_remote_grey_sync)));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_remote_bin <= '0;
        end else begin
            r_remote_bin <= w_remote_bin;
        end
    end

    assign bin_o        = r_bin;
    assign grey_o       = r_grey;
    assign grey_next_o  = w_grey_step;
    assign remote_bin_o = r_remote_bin;
    assign diff_o       = r_bin - r_remote_bin;

endmodule

// File: tb/tb_grey_pointer.sv
// Scoreboard bench for grey_pointer: an up-counting and a down-counting instance
// share stimulus; a reference model predicts every output after each edge.
module tb_grey_pointer;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       inc_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [3:0] remote_grey_i = 4'b0000;

    logic [3:0] up_bin, up_grey, up_gnext, up_rbin, up_diff;
    logic [3:0] dn_bin, dn_grey, dn_gnext, dn_rbin, dn_diff;

    always #5 clk_i = ~clk_i;

    grey_pointer #(.WIDTH(4), .SYNC_STAGES(2), .COUNT_DOWN(0)) dut_up (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .inc_i        (inc_i),
        .clr_i        (clr_i),
        .bin_o        (up_bin),
        .grey_o       (up_grey),
        .grey_next_o  (up_gnext),
        .remote_grey_i(remote_grey_i),
        .remote_bin_o (up_rbin),
        .diff_o       (up_diff)
    );

    grey_pointer #(.WIDTH(4), .SYNC_STAGES(2), .COUNT_DOWN(1)) dut_dn (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .inc_i        (inc_i),
        .clr_i        (clr_i),
        .bin_o        (dn_bin),
        .grey_o       (dn_grey),
        .grey_next_o  (dn_gnext),
        .remote_grey_i(remote_grey_i),
        .remote_bin_o (dn_rbin),
        .diff_o       (dn_diff)
    );

    typedef struct packed {
        logic [3:0] bin, grey, gnext, rbin, diff;
        logic [3:0] dbin, dgrey, dgnext, ddiff;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [3:0] m_up = 4'd0, m_dn = 4'd0, m_s1 = 4'd0, m_s2 = 4'd0, m_rb = 4'd0;

    function automatic logic [3:0] ref_b2g(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic inc, input logic clr,
                        input logic [3:0] rem, input string tag);
        exp_t e;
        @(negedge clk_i);
        rst_ni = rst;
        inc_i = inc;
        clr_i = clr;
        remote_grey_i = rem;
        if (!rst) begin
            m_up = 4'd0; m_dn = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0; m_rb = 4'd0;
        end else begin
            if (clr) begin
                m_up = 4'd0; m_dn = 4'd0;
            end else if (inc) begin
                m_up = m_up + 4'd1;
                m_dn = m_dn - 4'd1;
            end
            m_rb = ref_g2b(m_s2);
            m_s2 = m_s1;
            m_s1 = rem;
        end
        e.bin = m_up;   e.grey = ref_b2g(m_up);   e.gnext = ref_b2g(m_up + 4'd1);
        e.rbin = m_rb;  e.diff = m_up - m_rb;
        e.dbin = m_dn;  e.dgrey = ref_b2g(m_dn);  e.dgnext = ref_b2g(m_dn - 4'd1);
        e.ddiff = m_dn - m_rb;
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb_q.pop_front();
        check({tag, ".bin"},    up_bin,   e.bin);
        check({tag, ".grey"},   up_grey,  e.grey);
        check({tag, ".gnext"},  up_gnext, e.gnext);
        check({tag, ".rbin"},   up_rbin,  e.rbin);
        check({tag, ".diff"},   up_diff,  e.diff);
        check({tag, ".dbin"},   dn_bin,   e.dbin);
        check({tag, ".dgrey"},  dn_grey,  e.dgrey);
        check({tag, ".dgnext"}, dn_gnext, e.dgnext);
        check({tag, ".drbin"},  dn_rbin,  e.rbin);
        check({tag, ".ddiff"},  dn_diff,  e.ddiff);
    endtask

    logic [3:0] sweep_tbl [17] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
        4'b0000
    };

    initial begin
        logic [3:0] prev;

        // Reset held with inc and an all-ones remote pointer.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'b1111, "rst");
        check("rst.bin",    up_bin,   4'b0000);
        check("rst.grey",   up_grey,  4'b0000);
        check("rst.rbin",   up_rbin,  4'b0000);
        check("rst.diff",   up_diff,  4'b0000);
        check("rst.gnext",  up_gnext, 4'b0001);
        check("rst.dgnext", dn_gnext, 4'b1000);

        // Down mode: one step from reset.
        step(1'b1, 1'b1, 1'b0, 4'b0000, "down");
        check("down.bin",   dn_bin,   4'b1111);
        check("down.grey",  dn_grey,  4'b1000);
        check("down.gnext", dn_gnext, 4'b1001);

        // Full sweep with wrap.
        step(1'b0, 1'b0, 1'b0, 4'b0000, "sweep_rst");
        check("sweep.g0", up_grey, sweep_tbl[0]);
        prev = up_grey;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b1, 1'b0, 4'b0000, $sformatf("sweep%0d", k));
            check($sformatf("sweep.g%0d", k), up_grey, sweep_tbl[k]);
            check($sformatf("sweep.ham%0d", k), $countones(prev ^ up_grey), 1);
            check($sformatf("sweep.dham%0d", k), $countones(dn_grey ^ ref_b2g(dn_bin + 4'd1)), 1);
            prev = up_grey;
        end

        // Remote latency with local bin = 0111.
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 4'b0000, "lat_fill");
        check("lat.bin", up_bin, 4'b0111);
        step(1'b1, 1'b0, 1'b0, 4'b0110, "lat_t");
        check("lat.t0", up_rbin, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0110, "lat_t1");
        check("lat.t1", up_rbin, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0110, "lat_t2");
        check("lat.t2", up_rbin, 4'b0100);
        check("lat.diff", up_diff, 4'b0011);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 4'b1100, "lat_wrap");
        check("lat.rbin8", up_rbin, 4'b1000);
        check("lat.diffwrap", up_diff, 4'b1111);

        // Clear beats inc at bin = 0101; remote path untouched.
        step(1'b0, 1'b0, 1'b0, 4'b1100, "clr_rst");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 4'b1100, "clr_fill");
        check("clr.pre", up_bin, 4'b0101);
        check("clr.prerb", up_rbin, 4'b1000);
        step(1'b1, 1'b1, 1'b1, 4'b1100, "clr");
        check("clr.bin",  up_bin,  4'b0000);
        check("clr.grey", up_grey, 4'b0000);
        check("clr.rbin", up_rbin, 4'b1000);

        // Reset mid-operation with a fresh value inside the sync chain.
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b0, 4'b1100, "mid_fill");
        check("mid.pre", up_bin, 4'b1001);
        step(1'b1, 1'b0, 1'b0, 4'b0011, "mid_load");
        step(1'b0, 1'b0, 1'b0, 4'b1100, "mid_rst");
        check("mid.bin",  up_bin,  4'b0000);
        check("mid.grey", up_grey, 4'b0000);
        check("mid.rbin", up_rbin, 4'b0000);
        check("mid.diff", up_diff, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b0, 4'b1100, "mid_after");
            check($sformatf("mid.nostale%0d", k), up_rbin == 4'b0010, 0);
        end
        check("mid.final", up_rbin, 4'b1000);

        check("sb.empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
